exe_stage: RTL

- Execute stage of the 4-register, 8-bit teaching CPU pipeline, directly downstream of the decode stage.
- Latches the 28-bit ds_to_es_bus ({op_one_hot, ry_value, rx_value, pc}) into a pipeline register under a valid/allowin handshake.
- Performs the ALU operation selected by the one-hot opcode, including an iterative 8-cycle multiply.
- Presents the result to the write-back stage on es_to_ws_bus.

---
 rtl/exe_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage of the 4-register 8-bit teaching CPU: valid/allowin pipeline register plus ALU.
// Define ES_MUL_EN to build the iterative 8-cycle shift-and-add multiplier; otherwise op 0001 acts as NOP.
module exe_stage #(
    parameter int DATA_W   = 8,
    parameter int PC_W     = 8,
    parameter int DS_BUS_W = 4 + 2*DATA_W + PC_W,
    parameter int ES_BUS_W = 1 + DATA_W + PC_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ds_to_es_valid,
    input  logic [DS_BUS_W-1:0] ds_to_es_bus,
    output logic                es_allowin,
    output logic                es_to_ws_valid,
    output logic [ES_BUS_W-1:0] es_to_ws_bus,
    input  logic                ws_allowin,
    output logic                es_illegal
);
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_NOP = 4'b0000;

    logic                es_valid_q, es_valid_d;
    logic [DS_BUS_W-1:0] bus_q, bus_d;
    logic [3:0]          op;
    logic [DATA_W-1:0]   rx, ry, res;
    logic [PC_W-1:0]     pc;
    logic                res_flag, op_illegal, es_ready_go, accept, handoff;

    // Single-cycle ops; returns {flag, result}. The 9-bit sum/difference top bit is carry/borrow.
    function automatic logic [DATA_W:0] alu(input logic [3:0] f_op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        case (f_op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign op = bus_q[DS_BUS_W-1 -: 4];
    assign ry = bus_q[PC_W+DATA_W +: DATA_W];
    assign rx = bus_q[PC_W +: DATA_W];
    assign pc = bus_q[PC_W-1:0];

    always_comb begin
        op_illegal = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_MUL, OP_NOP: op_illegal = 1'b0;
            default:                                op_illegal = 1'b1;
        endcase
    end

`ifdef ES_MUL_EN
    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic                is_mul;

    assign is_mul      = (op == OP_MUL);
    assign es_ready_go = !is_mul || (state_q == MUL_DONE);

    // A new accept always restarts the FSM; only a MUL enters MUL_RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (accept) begin
            state_d = (ds_to_es_bus[DS_BUS_W-1 -: 4] == OP_MUL) ? MUL_RUN : IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                MUL_RUN: begin
                    if (ry[cnt_q])
                        acc_d = acc_q + ({{DATA_W{1'b0}}, rx} << cnt_q);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST)
                        state_d = MUL_DONE;
                end
                MUL_DONE: if (ws_allowin) state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end
`else
    assign es_ready_go = 1'b1;
`endif

    always_comb begin
        {res_flag, res} = alu(op, rx, ry);
`ifdef ES_MUL_EN
        if (is_mul) begin
            res      = acc_q[DATA_W-1:0];
            res_flag = |acc_q[2*DATA_W-1:DATA_W];
        end
`endif
    end

    assign es_allowin     = !es_valid_q || (es_ready_go && ws_allowin);
    assign es_to_ws_valid = es_valid_q && es_ready_go;
    assign accept         = ds_to_es_valid && es_allowin;
    assign handoff        = es_to_ws_valid && ws_allowin;
    assign es_to_ws_bus   = es_to_ws_valid ? {res_flag, res, pc} : '0;
    assign es_illegal     = es_valid_q && op_illegal;

    always_comb begin
        es_valid_d = es_valid_q;
        bus_d      = bus_q;
        if (accept) begin
            es_valid_d = 1'b1;
            bus_d      = ds_to_es_bus;
        end else if (handoff) begin
            es_valid_d = 1'b0;
        end
    end

    // Pipeline register boundary: decode -> execute.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            bus_q      <= bus_d;
        end
    end
endmodule
